dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory (D_Memory) between the RISCVCPU load/store port and a host port.
- The host port loads matrix1/matrix2 before a run and reads back the result matrix after `done`.
- Arbitration is round-robin, with an optional host lock for the preload phase.
- The block also keeps contention counters, reported alongside clock_count/instr_cnt for CPI analysis.

Parameters:
- ADDR_W, 8, word-address width of the data memory.
- DATA_W, 32, data word width.
- DEPTH, 256, number of implemented words; addresses >= DEPTH are out of range.

Ports:
- CLOCK_50 input 1: system clock, rising edge.
- reset input 1: asynchronous, active-high reset.
- cpu_req input 1: CPU access request; held with stable cpu_we/addr/wdata until granted.
- cpu_we input 1: 1 = write, 0 = read.
- cpu_addr input ADDR_W: CPU word address.
- cpu_wdata input DATA_W: CPU write data.
- cpu_gnt output 1: combinational grant; the access is issued this cycle.
- cpu_rvalid output 1: registered; high one cycle after a granted CPU read.
- cpu_rdata output DATA_W: read data, valid while cpu_rvalid is high.
- host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata: same meaning for the host port.
- host_lock input 1: while high, the host has absolute priority and the CPU is never granted.
- mem_en output 1: memory access enable.
- mem_we output 1: memory write enable.
- mem_addr output ADDR_W: memory address.
- mem_wdata output DATA_W: memory write data.
- mem_rdata input DATA_W: memory read data, 1-cycle synchronous latency.
- cpu_wait_cnt output 16: saturating count of cycles with cpu_req=1 and cpu_gnt=0.
- conflict_cnt output 16: saturating count of cycles with both requests high.

Behaviour:
- Reset (async, immediate):
  - last_gnt = HOST, so the CPU wins the first tie.
  - rd_owner = NONE.
  - All rvalid = 0, all rdata = 0, both counters = 0.
  - Combinational gnt/mem_* then evaluate from the inputs with the reset state.
- Arbitration (combinational from req, host_lock, last_gnt):
  - host_lock=1: host_gnt = host_req; cpu_gnt = 0.
  - Else, only one request high: that requester is granted.
  - Else, both high: grant the port that is not last_gnt.
  - Neither high: no grant, mem_en = 0.
  - At most one gnt is high per cycle. Worst-case CPU wait without lock is 1 cycle.
- last_gnt updates on the clock edge only when a grant occurs; otherwise it holds.
- Memory mux:
  - mem_en = any gnt.
  - mem_addr, mem_we, mem_wdata come from the granted port.
  - mem_* outputs are 0 when there is no grant.
- Out-of-range access (addr >= DEPTH):
  - The grant is still given; mem_en is forced to 0, so no memory access occurs.
  - A read still returns rvalid one cycle later with rdata = 0.
  - A write is dropped.
- Read return:
  - rd_owner is registered on a granted read (CPU, HOST or NONE), along with a registered out-of-range flag.
  - Next cycle, the owner's rvalid = 1 and its rdata = mem_rdata (or 0 if out of range). The other port's rdata holds its old value.
  - Writes produce no rvalid.
- Back-to-back operation:
  - A granted requester may keep req high with new addr/we/wdata and be granted again next cycle if uncontested. Throughput is 1 access/cycle.
  - The read of cycle N returns at N+1 regardless of the grant at N+1.
- Counters:
  - Increment by 1 per qualifying cycle.
  - Saturate at 16'hFFFF with no wrap.
  - Cleared only by reset.
- Reset mid-operation:
  - A pending rvalid is cancelled and never asserted after reset deasserts.
  - An in-flight write is whatever the memory captured at the edge; the arbiter gives no guarantee for it.
- host_lock changes take effect in the same cycle (combinational).

Test Plan:
- Reset: assert reset with both req high → gnt=0 and all outputs 0 while reset is asserted. Release, hold both req → cycle 1 cpu_gnt=1, cycle 2 host_gnt=1, alternating after that; conflict_cnt increments by 1 per cycle.
- Host preload: host_lock=1; host writes 16 words, addr 0..15, data = addr*3 → 16 consecutive host_gnt. cpu_req=1 throughout gets no grant, and cpu_wait_cnt = 16.
- Read latency: host read of addr 5 → host_rvalid=1 exactly one cycle later with host_rdata=15. cpu_rvalid stays 0.
- Interleaved reads: CPU reads addr 2 while the host reads addr 10, both held → CPU granted first, host next. cpu_rdata=6 and host_rdata=30, each on the cycle after its own grant.
- Out of range: DEPTH=16, CPU reads addr 20 → cpu_gnt=1, mem_en=0, next cycle cpu_rvalid=1 with cpu_rdata=0. A CPU write to addr 20 leaves memory unchanged.
- Saturation and reset: preload cpu_wait_cnt near max by holding host_lock with cpu_req for 65540 cycles → counter reads 16'hFFFF. Assert reset one cycle after a granted read → no rvalid after release, and the counter reads 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous data memory
// between the CPU load/store port and a host port, with contention counters.
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              host_lock,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       cpu_wait_cnt,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_HOST} owner_t;

    localparam int unsigned DEPTH_U = DEPTH;

    logic              last_host_q;
    owner_t            rd_owner_q, rd_owner_d;
    logic              rd_oor_q;
    logic [DATA_W-1:0] cpu_rdata_q, host_rdata_q;
    logic [15:0]       cpu_wait_q, cpu_wait_d;
    logic [15:0]       conflict_q, conflict_d;

    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_range;
    logic [DATA_W-1:0] ret_data;

    // Grants are suppressed while reset is held so nothing reaches memory.
    always_comb begin
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (!reset) begin
            if (host_lock) begin
                host_gnt = host_req;
            end else if (cpu_req && host_req) begin
                cpu_gnt  = last_host_q;
                host_gnt = !last_host_q;
            end else begin
                cpu_gnt  = cpu_req;
                host_gnt = host_req;
            end
        end
    end

    assign any_gnt   = cpu_gnt | host_gnt;
    assign sel_we    = host_gnt ? host_we    : cpu_we;
    assign sel_addr  = host_gnt ? host_addr  : cpu_addr;
    assign sel_wdata = host_gnt ? host_wdata : cpu_wdata;
    assign in_range  = int'(sel_addr) < DEPTH_U;

    assign mem_en    = any_gnt && in_range;
    assign mem_we    = mem_en && sel_we;
    assign mem_addr  = any_gnt ? sel_addr  : '0;
    assign mem_wdata = any_gnt ? sel_wdata : '0;

    always_comb begin
        rd_owner_d = OWN_NONE;
        if (any_gnt && !sel_we) begin
            rd_owner_d = host_gnt ? OWN_HOST : OWN_CPU;
        end
        cpu_wait_d = cpu_wait_q;
        if (cpu_req && !cpu_gnt && cpu_wait_q != 16'hFFFF) begin
            cpu_wait_d = cpu_wait_q + 16'd1;
        end
        conflict_d = conflict_q;
        if (cpu_req && host_req && conflict_q != 16'hFFFF) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    // Memory data arrives the cycle after the grant; the port not owning the
    // return keeps showing its last captured word.
    assign ret_data    = rd_oor_q ? '0 : mem_rdata;
    assign cpu_rvalid  = (rd_owner_q == OWN_CPU);
    assign host_rvalid = (rd_owner_q == OWN_HOST);
    assign cpu_rdata   = cpu_rvalid  ? ret_data : cpu_rdata_q;
    assign host_rdata  = host_rvalid ? ret_data : host_rdata_q;

    assign cpu_wait_cnt = cpu_wait_q;
    assign conflict_cnt = conflict_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            last_host_q  <= 1'b1;
            rd_owner_q   <= OWN_NONE;
            rd_oor_q     <= 1'b0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
            cpu_wait_q   <= '0;
            conflict_q   <= '0;
        end else begin
            if (any_gnt) begin
                last_host_q <= host_gnt;
            end
            rd_owner_q   <= rd_owner_d;
            rd_oor_q     <= any_gnt && !in_range;
            cpu_rdata_q  <= cpu_rdata;
            host_rdata_q <= host_rdata;
            cpu_wait_q   <= cpu_wait_d;
            conflict_q   <= conflict_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous memory.
module tb_dmem_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    logic              CLOCK_50 = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we, host_req, host_we, host_lock;
    logic [ADDR_W-1:0] cpu_addr, host_addr;
    logic [DATA_W-1:0] cpu_wdata, host_wdata;
    logic              cpu_gnt, cpu_rvalid, host_gnt, host_rvalid;
    logic [DATA_W-1:0] cpu_rdata, host_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [15:0]       cpu_wait_cnt, conflict_cnt;

    logic [DATA_W-1:0] mem_model [256];

    int checks = 0;
    int errors = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .host_lock(host_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .cpu_wait_cnt(cpu_wait_cnt), .conflict_cnt(conflict_cnt)
    );

    always @(posedge CLOCK_50) begin
        if (mem_en) begin
            if (mem_we) mem_model[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_model[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge CLOCK_50);
    endtask

    task automatic cpu_drive(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata);
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    endtask

    task automatic host_drive(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wdata);
        host_req = req; host_we = we; host_addr = addr; host_wdata = wdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = '0;
        mem_model[20] = 32'hDEAD_BEEF;
        mem_rdata = '0;
        reset = 1'b1;
        host_lock = 1'b0;
        cpu_drive(1'b1, 1'b0, 8'd0, '0);
        host_drive(1'b1, 1'b0, 8'd1, '0);

        // Reset held with both requests high
        repeat (2) next_cycle();
        #1;
        check("rst_cpu_gnt", {31'b0, cpu_gnt}, 0);
        check("rst_host_gnt", {31'b0, host_gnt}, 0);
        check("rst_mem_en", {31'b0, mem_en}, 0);
        check("rst_mem_addr", {24'b0, mem_addr}, 0);
        check("rst_rvalid", {30'b0, cpu_rvalid, host_rvalid}, 0);
        check("rst_rdata", cpu_rdata | host_rdata, 0);
        check("rst_counters", {cpu_wait_cnt, conflict_cnt}, 0);

        // Release: CPU wins first tie, then alternation
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #2;
            check("rr_cpu_gnt", {31'b0, cpu_gnt}, (k % 2 == 1) ? 1 : 0);
            check("rr_host_gnt", {31'b0, host_gnt}, (k % 2 == 0) ? 1 : 0);
            check("rr_conflict", {16'b0, conflict_cnt}, k - 1);
            next_cycle();
        end
        check("rr_conflict_end", {16'b0, conflict_cnt}, 4);
        check("rr_wait_end", {16'b0, cpu_wait_cnt}, 2);
        cpu_drive(1'b0, 1'b0, '0, '0);
        host_drive(1'b0, 1'b0, '0, '0);
        do_reset();

        // Host preload under lock while the CPU keeps requesting
        host_lock = 1'b1;
        cpu_drive(1'b1, 1'b0, 8'd0, '0);
        for (int i = 0; i < 16; i++) begin
            host_drive(1'b1, 1'b1, 8'(i), 32'(i * 3));
            #2;
            check("pre_host_gnt", {31'b0, host_gnt}, 1);
            check("pre_cpu_gnt", {31'b0, cpu_gnt}, 0);
            next_cycle();
        end
        host_drive(1'b0, 1'b0, '0, '0);
        cpu_drive(1'b0, 1'b0, '0, '0);
        host_lock = 1'b0;
        #1;
        check("pre_wait_cnt", {16'b0, cpu_wait_cnt}, 16);
        check("pre_mem7", mem_model[7], 21);
        check("pre_mem15", mem_model[15], 45);

        // Host read latency
        host_drive(1'b1, 1'b0, 8'd5, '0);
        #2;
        check("lat_host_gnt", {31'b0, host_gnt}, 1);
        check("lat_rvalid_early", {31'b0, host_rvalid}, 0);
        next_cycle();
        host_drive(1'b0, 1'b0, '0, '0);
        #1;
        check("lat_host_rvalid", {31'b0, host_rvalid}, 1);
        check("lat_host_rdata", host_rdata, 15);
        check("lat_cpu_rvalid", {31'b0, cpu_rvalid}, 0);
        next_cycle();
        #1;
        check("lat_rvalid_drop", {31'b0, host_rvalid}, 0);
        check("lat_rdata_hold", host_rdata, 15);

        // Interleaved reads: host was granted last, so CPU goes first
        cpu_drive(1'b1, 1'b0, 8'd2, '0);
        host_drive(1'b1, 1'b0, 8'd10, '0);
        #2;
        check("il_cpu_gnt", {31'b0, cpu_gnt}, 1);
        check("il_host_wait", {31'b0, host_gnt}, 0);
        check("il_mem_addr", {24'b0, mem_addr}, 2);
        next_cycle();
        cpu_drive(1'b0, 1'b0, '0, '0);
        #1;
        check("il_host_gnt", {31'b0, host_gnt}, 1);
        check("il_cpu_rvalid", {31'b0, cpu_rvalid}, 1);
        check("il_cpu_rdata", cpu_rdata, 6);
        check("il_host_rvalid0", {31'b0, host_rvalid}, 0);
        next_cycle();
        host_drive(1'b0, 1'b0, '0, '0);
        #1;
        check("il_host_rvalid", {31'b0, host_rvalid}, 1);
        check("il_host_rdata", host_rdata, 30);
        check("il_cpu_rvalid_off", {31'b0, cpu_rvalid}, 0);
        check("il_cpu_rdata_hold", cpu_rdata, 6);

        // Out-of-range read then write at address 20
        cpu_drive(1'b1, 1'b0, 8'd20, '0);
        #2;
        check("oor_rd_gnt", {31'b0, cpu_gnt}, 1);
        check("oor_rd_mem_en", {31'b0, mem_en}, 0);
        next_cycle();
        cpu_drive(1'b1, 1'b1, 8'd20, 32'h0000_1234);
        #1;
        check("oor_rvalid", {31'b0, cpu_rvalid}, 1);
        check("oor_rdata", cpu_rdata, 0);
        check("oor_wr_gnt", {31'b0, cpu_gnt}, 1);
        check("oor_wr_mem_en", {31'b0, mem_en}, 0);
        next_cycle();
        cpu_drive(1'b0, 1'b0, '0, '0);
        #1;
        check("oor_wr_rvalid", {31'b0, cpu_rvalid}, 0);
        check("oor_mem20", mem_model[20], 32'hDEAD_BEEF);
        check("oor_conflict", {16'b0, conflict_cnt}, 17);

        // Saturate the wait counter under lock
        host_lock = 1'b1;
        cpu_drive(1'b1, 1'b0, 8'd3, '0);
        repeat (65540) next_cycle();
        #1;
        check("sat_wait_cnt", {16'b0, cpu_wait_cnt}, 32'h0000_FFFF);
        check("sat_conflict", {16'b0, conflict_cnt}, 17);

        // Granted read, then reset during its return cycle
        host_lock = 1'b0;
        #1;
        check("sat_cpu_gnt", {31'b0, cpu_gnt}, 1);
        next_cycle();
        reset = 1'b1;
        cpu_drive(1'b0, 1'b0, '0, '0);
        #1;
        check("mid_rst_rvalid", {31'b0, cpu_rvalid}, 0);
        check("mid_rst_wait", {16'b0, cpu_wait_cnt}, 0);
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("post_rst_rvalid", {30'b0, cpu_rvalid, host_rvalid}, 0);
            next_cycle();
        end
        check("post_rst_wait", {16'b0, cpu_wait_cnt}, 0);
        check("post_rst_rdata", cpu_rdata, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
